// File: rtl/vga_frame_scheduler_pkg.sv
// Shared VGA timing defaults, timing-FSM state encodings and the display-state bundle
// used by the frame scheduler and its sync delay line.
package vga_frame_scheduler_pkg;

  localparam int DEF_CNTR_WIDTH_H = 11;
  localparam int DEF_CNTR_WIDTH_V = 10;
  localparam int DEF_H_VISIBLE    = 640;
  localparam int DEF_H_FRONT      = 16;
  localparam int DEF_H_SYNC       = 96;
  localparam int DEF_H_BACK       = 48;
  localparam int DEF_V_VISIBLE    = 480;
  localparam int DEF_V_FRONT      = 10;
  localparam int DEF_V_SYNC       = 2;
  localparam int DEF_V_BACK       = 33;
  localparam int DEF_PIPE_LAT     = 2;

  typedef enum logic [1:0] {
    H_ST_ACTIVE = 2'd0,
    H_ST_FRONT  = 2'd1,
    H_ST_SYNC   = 2'd2,
    H_ST_BACK   = 2'd3
  } h_state_e;

  typedef enum logic [1:0] {
    V_ST_ACTIVE = 2'd0,
    V_ST_FRONT  = 2'd1,
    V_ST_SYNC   = 2'd2,
    V_ST_BACK   = 2'd3
  } v_state_e;

  // Everything the producer hands over in one update, published atomically per frame.
  typedef struct packed {
    logic [11:0]  highlighted;
    logic [3:0]   basket_num;
    logic [47:0]  basket_ids;
    logic [239:0] numbers;
    logic [19:0]  total_price;
  } display_t;

  function automatic bit timing_fits(input int total, input int width);
    return total <= (1 << width);
  endfunction

endpackage

// File: rtl/vga_frame_scheduler_sync_delay.sv
// Reset-loaded shift register that delays {HS, VS, BLANK_N} to match pixel-path latency.
// DEPTH of zero degenerates to a plain wire.
module vga_sync_delay #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = CLOCK ^ RESET_N;
      assign q_o = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] stage_d;
        if (gi == 0) begin : g_first
          assign stage_d = d_i;
        end else begin : g_rest
          assign stage_d = stage_q[gi-1];
        end
        always_ff @(posedge CLOCK) begin
          if (!RESET_N) begin
            stage_q[gi] <= RESET_VAL;
          end else begin
            stage_q[gi] <= stage_d;
          end
        end
      end
      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_frame_scheduler.sv
// VGA timing owner: H/V counters and region FSMs, latency-matched sync/blank, and
// tear-free publication of producer display state at the start of vertical blanking.
module vga_frame_scheduler
  import vga_frame_scheduler_pkg::*;
#(
  parameter int CNTR_WIDTH_H = DEF_CNTR_WIDTH_H,
  parameter int CNTR_WIDTH_V = DEF_CNTR_WIDTH_V,
  parameter int H_VISIBLE    = DEF_H_VISIBLE,
  parameter int H_FRONT      = DEF_H_FRONT,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BACK       = DEF_H_BACK,
  parameter int V_VISIBLE    = DEF_V_VISIBLE,
  parameter int V_FRONT      = DEF_V_FRONT,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BACK       = DEF_V_BACK,
  parameter int PIPE_LAT     = DEF_PIPE_LAT
) (
  input  logic                    CLOCK,
  input  logic                    RESET_N,
  input  logic                    UPDATE_REQ,
  input  logic [11:0]             HighlightedProductList_in,
  input  logic [3:0]              BasketProductNum_in,
  input  logic [47:0]             BasketProductIDList_in,
  input  logic [239:0]            numbers_in,
  input  logic [19:0]             total_price_in,
  output logic                    UPDATE_ACK,
  output logic [CNTR_WIDTH_H-1:0] CounterX,
  output logic [CNTR_WIDTH_V-1:0] CounterY,
  output logic [11:0]             HighlightedProductList,
  output logic [3:0]              BasketProductNum,
  output logic [47:0]             BasketProductIDList,
  output logic [239:0]            numbers,
  output logic [19:0]             total_price,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic                    VGA_BLANK_N,
  output logic                    VGA_SYNC_N,
  output logic                    FRAME_START,
  output logic                    LINE_START
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (!timing_fits(H_TOTAL, CNTR_WIDTH_H)) begin : g_h_width_err
      $error("horizontal timing total does not fit CNTR_WIDTH_H");
    end
    if (!timing_fits(V_TOTAL, CNTR_WIDTH_V)) begin : g_v_width_err
      $error("vertical timing total does not fit CNTR_WIDTH_V");
    end
    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1)
    begin : g_region_err
      $error("every porch and sync region needs at least one pixel/line");
    end
  endgenerate

  localparam logic [CNTR_WIDTH_H-1:0] H_FRONT_AT = CNTR_WIDTH_H'(H_VISIBLE);
  localparam logic [CNTR_WIDTH_H-1:0] H_SYNC_AT  = CNTR_WIDTH_H'(H_VISIBLE + H_FRONT);
  localparam logic [CNTR_WIDTH_H-1:0] H_BACK_AT  = CNTR_WIDTH_H'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNTR_WIDTH_H-1:0] H_LAST     = CNTR_WIDTH_H'(H_TOTAL - 1);
  localparam logic [CNTR_WIDTH_V-1:0] V_FRONT_AT = CNTR_WIDTH_V'(V_VISIBLE);
  localparam logic [CNTR_WIDTH_V-1:0] V_SYNC_AT  = CNTR_WIDTH_V'(V_VISIBLE + V_FRONT);
  localparam logic [CNTR_WIDTH_V-1:0] V_BACK_AT  = CNTR_WIDTH_V'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNTR_WIDTH_V-1:0] V_LAST     = CNTR_WIDTH_V'(V_TOTAL - 1);

  logic [CNTR_WIDTH_H-1:0] x_q, x_d;
  logic [CNTR_WIDTH_V-1:0] y_q, y_d;
  logic                    x_wrap;
  h_state_e                h_state_q, h_state_d;
  v_state_e                v_state_q, v_state_d;
  logic                    run_q;
  logic                    frame_start_q, frame_start_d;
  logic                    line_start_q, line_start_d;
  display_t                in_bus;
  display_t                pending_q, pending_d;
  logic                    pending_vld_q, pending_vld_d;
  display_t                shadow_q, shadow_d;
  logic                    ack_q, ack_d;
  logic                    publish;
  logic [2:0]              raw_sync, dly_sync;

  always_comb begin
    x_wrap = (x_q == H_LAST);
    x_d    = x_wrap ? '0 : x_q + 1'b1;
    y_d    = y_q;
    if (x_wrap) begin
      y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end
    frame_start_d = (x_d == '0) && (y_d == '0);
    line_start_d  = (x_d == '0);
  end

  // Region FSMs look at the next counter value so state and counters stay in step.
  always_comb begin
    h_state_d = h_state_q;
    case (h_state_q)
      H_ST_ACTIVE: if (x_d == H_FRONT_AT) h_state_d = H_ST_FRONT;
      H_ST_FRONT:  if (x_d == H_SYNC_AT)  h_state_d = H_ST_SYNC;
      H_ST_SYNC:   if (x_d == H_BACK_AT)  h_state_d = H_ST_BACK;
      H_ST_BACK:   if (x_d == '0)         h_state_d = H_ST_ACTIVE;
      default:                            h_state_d = H_ST_ACTIVE;
    endcase
  end

  always_comb begin
    v_state_d = v_state_q;
    if (x_wrap) begin
      case (v_state_q)
        V_ST_ACTIVE: if (y_d == V_FRONT_AT) v_state_d = V_ST_FRONT;
        V_ST_FRONT:  if (y_d == V_SYNC_AT)  v_state_d = V_ST_SYNC;
        V_ST_SYNC:   if (y_d == V_BACK_AT)  v_state_d = V_ST_BACK;
        V_ST_BACK:   if (y_d == '0)         v_state_d = V_ST_ACTIVE;
        default:                            v_state_d = V_ST_ACTIVE;
      endcase
    end
  end

  always_comb begin
    in_bus.highlighted = HighlightedProductList_in;
    in_bus.basket_num  = BasketProductNum_in;
    in_bus.basket_ids  = BasketProductIDList_in;
    in_bus.numbers     = numbers_in;
    in_bus.total_price = total_price_in;
  end

  // Publish happens only on the single cycle entering vertical front porch;
  // a request landing on that very cycle bypasses the pending copy.
  assign publish = (x_q == '0) && (y_q == V_FRONT_AT);

  always_comb begin
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    shadow_d      = shadow_q;
    ack_d         = 1'b0;
    if (publish) begin
      if (UPDATE_REQ) begin
        shadow_d      = in_bus;
        pending_d     = '0;
        pending_vld_d = 1'b0;
        ack_d         = 1'b1;
      end else if (pending_vld_q) begin
        shadow_d      = pending_q;
        pending_d     = '0;
        pending_vld_d = 1'b0;
        ack_d         = 1'b1;
      end
    end else if (UPDATE_REQ) begin
      pending_d     = in_bus;
      pending_vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      x_q           <= '0;
      y_q           <= '0;
      h_state_q     <= H_ST_ACTIVE;
      v_state_q     <= V_ST_ACTIVE;
      run_q         <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      shadow_q      <= '0;
      ack_q         <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      run_q         <= 1'b1;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      shadow_q      <= shadow_d;
      ack_q         <= ack_d;
    end
  end

  // run_q keeps BLANK_N low in the reset cycle even when the delay line is a wire.
  assign raw_sync = {h_state_q != H_ST_SYNC,
                     v_state_q != V_ST_SYNC,
                     run_q && (h_state_q == H_ST_ACTIVE) && (v_state_q == V_ST_ACTIVE)};

  vga_sync_delay #(
    .WIDTH     (3),
    .DEPTH     (PIPE_LAT),
    .RESET_VAL (3'b110)
  ) u_sync_delay (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .d_i     (raw_sync),
    .q_o     (dly_sync)
  );

  assign VGA_HS                 = dly_sync[2];
  assign VGA_VS                 = dly_sync[1];
  assign VGA_BLANK_N            = dly_sync[0];
  assign VGA_SYNC_N             = 1'b0;
  assign CounterX               = x_q;
  assign CounterY               = y_q;
  assign FRAME_START            = frame_start_q;
  assign LINE_START             = line_start_q;
  assign UPDATE_ACK             = ack_q;
  assign HighlightedProductList = shadow_q.highlighted;
  assign BasketProductNum       = shadow_q.basket_num;
  assign BasketProductIDList    = shadow_q.basket_ids;
  assign numbers                = shadow_q.numbers;
  assign total_price            = shadow_q.total_price;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench for vga_frame_scheduler on a shrunken raster (34 x 19) so whole frames stay short;
// a second instance with zero pipe latency shares the stimulus.
module tb_vga_frame_scheduler;

  localparam int HV = 20, HF = 4, HS = 6, HB = 4, HT = HV + HF + HS + HB;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic         CLOCK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         UPDATE_REQ = 1'b0;
  logic [11:0]  hl_in = '0;
  logic [3:0]   bnum_in = '0;
  logic [47:0]  bid_in = '0;
  logic [239:0] num_in = '0;
  logic [19:0]  tot_in = '0;

  logic         ack, hs, vs, blank_n, sync_n, fs, ls;
  logic [10:0]  cx;
  logic [9:0]   cy;
  logic [11:0]  hl;
  logic [3:0]   bnum;
  logic [47:0]  bid;
  logic [239:0] num;
  logic [19:0]  tot;

  logic         ack0, hs0, vs0, blank0, sync0, fs0, ls0;
  logic [10:0]  cx0;
  logic [9:0]   cy0;
  logic [11:0]  hl0;
  logic [3:0]   bnum0;
  logic [47:0]  bid0;
  logic [239:0] num0;
  logic [19:0]  tot0;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0, fs_cnt = 0, ls_cnt = 0, misalign = 0, hs_low = 0, vs_low = 0, blank_hi = 0;
  int snap_ack, snap_fs, snap_ls, snap_mis, snap_hs, snap_vs, snap_bl;

  always #5 CLOCK = ~CLOCK;

  vga_frame_scheduler #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .PIPE_LAT(2)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .UPDATE_REQ(UPDATE_REQ),
    .HighlightedProductList_in(hl_in), .BasketProductNum_in(bnum_in),
    .BasketProductIDList_in(bid_in), .numbers_in(num_in), .total_price_in(tot_in),
    .UPDATE_ACK(ack), .CounterX(cx), .CounterY(cy),
    .HighlightedProductList(hl), .BasketProductNum(bnum), .BasketProductIDList(bid),
    .numbers(num), .total_price(tot), .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n),
    .VGA_SYNC_N(sync_n), .FRAME_START(fs), .LINE_START(ls)
  );

  vga_frame_scheduler #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .PIPE_LAT(0)
  ) dut0 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .UPDATE_REQ(UPDATE_REQ),
    .HighlightedProductList_in(hl_in), .BasketProductNum_in(bnum_in),
    .BasketProductIDList_in(bid_in), .numbers_in(num_in), .total_price_in(tot_in),
    .UPDATE_ACK(ack0), .CounterX(cx0), .CounterY(cy0),
    .HighlightedProductList(hl0), .BasketProductNum(bnum0), .BasketProductIDList(bid0),
    .numbers(num0), .total_price(tot0), .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_N(blank0),
    .VGA_SYNC_N(sync0), .FRAME_START(fs0), .LINE_START(ls0)
  );

  always @(negedge CLOCK) begin
    if (ack) ack_cnt++;
    if (fs) fs_cnt++;
    if (ls) ls_cnt++;
    if (fs && !(cx == 0 && cy == 0)) misalign++;
    if (ls && cx != 0) misalign++;
    if (!hs) hs_low++;
    if (!vs) vs_low++;
    if (blank_n) blank_hi++;
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_xy(input int x, input int y);
    int n = 0;
    while (!(cx == 11'(x) && cy == 10'(y)) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    if (n >= 2 * FRAME) begin
      checks++;
      errors++;
      $error("FAIL wait_xy timeout: observed X=%0d Y=%0d expected X=%0d Y=%0d", cx, cy, x, y);
    end
  endtask

  task automatic pulse_req(input logic [11:0] h);
    UPDATE_REQ = 1'b1;
    hl_in = h;
    tick();
    UPDATE_REQ = 1'b0;
    hl_in = 12'hfff;
  endtask

  task automatic snap();
    snap_ack = ack_cnt; snap_fs = fs_cnt; snap_ls = ls_cnt; snap_mis = misalign;
    snap_hs = hs_low; snap_vs = vs_low; snap_bl = blank_hi;
  endtask

  initial begin
    // Reset held for three cycles
    repeat (3) tick();
    check("rst_x", 64'(cx), 64'd0);
    check("rst_y", 64'(cy), 64'd0);
    check("rst_hs_vs", 64'({hs, vs}), 64'b11);
    check("rst_blank", 64'(blank_n), 64'd0);
    check("rst_blank_lat0", 64'(blank0), 64'd0);
    check("rst_ack_fs_ls", 64'({ack, fs, ls}), 64'd0);
    check("rst_shadow", 64'({hl, tot}), 64'd0);
    check("sync_n", 64'({sync_n, sync0}), 64'd0);
    RESET_N = 1'b1;

    // Horizontal timing on line 1 (lat 2 and lat 0)
    wait_xy(0, 1);  check("blank_lat0_x0", 64'(blank0), 64'd1);
    wait_xy(1, 1);  check("blank_x1", 64'(blank_n), 64'd0);
    wait_xy(2, 1);  check("blank_x2", 64'(blank_n), 64'd1);
    wait_xy(19, 1); check("blank_lat0_x19", 64'(blank0), 64'd1);
    wait_xy(20, 1); check("blank_lat0_x20", 64'(blank0), 64'd0);
    wait_xy(21, 1); check("blank_x21", 64'(blank_n), 64'd1);
    wait_xy(22, 1); check("blank_x22", 64'(blank_n), 64'd0);
    wait_xy(23, 1); check("hs_lat0_x23", 64'(hs0), 64'd1);
    wait_xy(24, 1); check("hs_lat0_x24", 64'(hs0), 64'd0);
    wait_xy(25, 1); check("hs_x25", 64'(hs), 64'd1);
    wait_xy(26, 1); check("hs_x26", 64'(hs), 64'd0);
    wait_xy(31, 1); check("hs_x31", 64'(hs), 64'd0);
    wait_xy(32, 1); check("hs_x32", 64'(hs), 64'd1);
    wait_xy(33, 1); tick();
    check("x_wrap", 64'({cy, cx}), 64'({10'd2, 11'd0}));

    // Vertical timing
    wait_xy(5, 12); check("blank_vfront", 64'(blank_n), 64'd0);
    check("vs_y12", 64'(vs), 64'd1);
    wait_xy(0, 14); check("vs_lat0_y14", 64'(vs0), 64'd0);
    wait_xy(1, 14); check("vs_y14_x1", 64'(vs), 64'd1);
    wait_xy(2, 14); check("vs_y14_x2", 64'(vs), 64'd0);
    wait_xy(1, 16); check("vs_y16_x1", 64'(vs), 64'd0);
    wait_xy(2, 16); check("vs_y16_x2", 64'(vs), 64'd1);

    // One full frame of statistics
    wait_xy(0, 0);
    snap();
    repeat (FRAME) tick();
    check("frame_period", 64'({cy, cx}), 64'd0);
    check("frame_start_cnt", 64'(fs_cnt - snap_fs), 64'd1);
    check("line_start_cnt", 64'(ls_cnt - snap_ls), 64'(VT));
    check("start_misalign", 64'(misalign - snap_mis), 64'd0);
    check("hs_low_cycles", 64'(hs_low - snap_hs), 64'(HS * VT));
    check("vs_low_cycles", 64'(vs_low - snap_vs), 64'(VS * HT));
    check("blank_hi_cycles", 64'(blank_hi - snap_bl), 64'(HV * VV));
    check("no_ack_idle", 64'(ack_cnt - snap_ack), 64'd0);

    // Single update published at start of vertical blanking
    wait_xy(10, 3);
    snap();
    UPDATE_REQ = 1'b1; hl_in = 12'h004; tot_in = 20'd1250; bnum_in = 4'h3; num_in = {60{4'h5}};
    tick();
    UPDATE_REQ = 1'b0; hl_in = 12'hfff; tot_in = '0; bnum_in = '0; num_in = '0;
    check("upd_hold_hl", 64'(hl), 64'd0);
    wait_xy(0, 12);
    check("upd_hold_pub", 64'({hl, tot}), 64'd0);
    check("upd_no_early_ack", 64'(ack), 64'd0);
    tick();
    check("upd_hl", 64'(hl), 64'h004);
    check("upd_total", 64'(tot), 64'd1250);
    check("upd_bnum", 64'(bnum), 64'h3);
    check("upd_numbers", 64'(num[15:0]), 64'h5555);
    check("upd_ack", 64'(ack), 64'd1);
    tick();
    check("upd_ack_low", 64'(ack), 64'd0);
    wait_xy(2, 12);
    check("upd_ack_once", 64'(ack_cnt - snap_ack), 64'd1);
    check("upd_hl_kept", 64'(hl), 64'h004);

    // Last request before publish wins
    wait_xy(5, 1);
    snap();
    pulse_req(12'h004);
    wait_xy(5, 8);
    pulse_req(12'h010);
    wait_xy(0, 12);
    check("lastwin_hold", 64'(hl), 64'h004);
    wait_xy(2, 12);
    check("lastwin_hl", 64'(hl), 64'h010);
    check("lastwin_one_ack", 64'(ack_cnt - snap_ack), 64'd1);

    // Request on the publish cycle overrides pending and clears it
    wait_xy(5, 3);
    pulse_req(12'h004);
    wait_xy(0, 12);
    snap();
    pulse_req(12'h020);
    check("bypass_hl", 64'(hl), 64'h020);
    check("bypass_ack", 64'(ack), 64'd1);
    tick();
    wait_xy(2, 12);
    check("bypass_no_second_ack", 64'(ack_cnt - snap_ack), 64'd1);
    check("bypass_hl_kept", 64'(hl), 64'h020);

    // Mid-frame reset discards pending update
    wait_xy(5, 3);
    pulse_req(12'h004);
    wait_xy(0, 8);
    snap();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    check("midrst_xy", 64'({cy, cx}), 64'd0);
    check("midrst_hs_vs", 64'({hs, vs}), 64'b11);
    check("midrst_blank", 64'({blank_n, blank0}), 64'd0);
    check("midrst_shadow", 64'(hl), 64'd0);
    wait_xy(2, 12);
    check("midrst_no_ack", 64'(ack_cnt - snap_ack), 64'd0);
    check("midrst_shadow_pub", 64'(hl), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
